// File: rtl/fpu_vector_driver_pkg.sv
// Shared types for the FP ALU vector driver.
// Op codes, vector record, state encoding and NaN helper.
package fpu_pkg;

   typedef enum logic [1:0] {
      FP_ADD = 2'd0,
      FP_SUB = 2'd1,
      FP_MUL = 2'd2,
      FP_DIV = 2'd3
   } fpu_op_e;

   typedef struct packed {
      fpu_op_e     op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } fpu_vec_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_CHECK,
      ST_FIN
   } drv_state_e;

   function automatic logic is_nan(input logic [31:0] v);
      return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
   endfunction

endpackage

// File: rtl/fpu_vector_driver_if.sv
// Request/response link between the vector driver and the FP ALU.
// master = driver side, slave = ALU side.
interface fpu_vector_driver_if;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        rsp_valid;
   logic [31:0] rsp_result;

   modport master (
      output req_valid, req_op, req_a, req_b,
      input  req_ready, rsp_valid, rsp_result
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b,
      output req_ready, rsp_valid, rsp_result
   );
endinterface

// File: rtl/fpu_vector_driver_ram.sv
// Vector table: synchronous write, combinational read.
// Contents are deliberately left unreset.
module fpu_vec_ram
   import fpu_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  fpu_vec_t      wdata,
   input  logic [AW-1:0] raddr,
   output fpu_vec_t      rdata
);
   fpu_vec_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/fpu_vector_driver.sv
// Built-in self-test driver for the FP ALU: replays stored
// vectors, compares each response and tallies results.
module fpu_vector_driver
   import fpu_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 64,
   parameter int NAN_EQ  = 1,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          vec_we,
   input  logic [AW-1:0] vec_addr,
   input  logic [1:0]    vec_op,
   input  logic [31:0]   vec_a,
   input  logic [31:0]   vec_b,
   input  logic [31:0]   vec_exp,
   input  logic [CW-1:0] num_vec,
   input  logic          start,
   fpu_vector_driver_if.master alu,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] pass_cnt,
   output logic [CW-1:0] fail_cnt,
   output logic [AW-1:0] first_fail,
   output logic          fail_seen,
   output logic          timeout_err
);
   localparam int TW = $clog2(TIMEOUT + 1);

   drv_state_e    state, state_n;
   logic [CW-1:0] idx;
   logic [CW-1:0] run_len;
   logic [TW-1:0] tmo;
   logic [31:0]   res;
   fpu_vec_t      ent;
   fpu_vec_t      wr;

   logic issue, hs, to_ev, match;
   logic fail_ev, adv, last;

   assign wr = '{op: fpu_op_e'(vec_op), a: vec_a,
                 b: vec_b, exp: vec_exp};

   fpu_vec_ram #(.DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .we    (vec_we && !busy),
      .waddr (vec_addr),
      .wdata (wr),
      .raddr (idx[AW-1:0]),
      .rdata (ent)
   );

   assign issue = (state == ST_ISSUE);
   assign busy  = issue || (state == ST_WAIT)
               || (state == ST_CHECK);
   assign done  = (state == ST_FIN);

   // Request fields read as zero whenever no request is offered.
   assign alu.req_valid = issue;
   assign alu.req_op    = issue ? ent.op  : 2'd0;
   assign alu.req_a     = issue ? ent.a   : 32'd0;
   assign alu.req_b     = issue ? ent.b   : 32'd0;

   always_comb begin
      hs      = issue && alu.req_ready;
      to_ev   = (state == ST_WAIT) && !alu.rsp_valid
             && (tmo == TW'(1));
      match   = (res == ent.exp)
             || ((NAN_EQ != 0) && is_nan(res)
                 && is_nan(ent.exp));
      fail_ev = to_ev || ((state == ST_CHECK) && !match);
      adv     = to_ev || (state == ST_CHECK);
      last    = ((idx + CW'(1)) == run_len);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         ST_IDLE:
            if (start)
               state_n = (num_vec == '0) ? ST_FIN : ST_ISSUE;
         ST_ISSUE:
            if (hs) state_n = ST_WAIT;
         ST_WAIT:
            if (alu.rsp_valid) state_n = ST_CHECK;
            else if (to_ev)
               state_n = last ? ST_FIN : ST_ISSUE;
         ST_CHECK:
            state_n = last ? ST_FIN : ST_ISSUE;
         ST_FIN:
            state_n = ST_IDLE;
         default:
            state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx         <= '0;
         run_len     <= '0;
         tmo         <= '0;
         res         <= '0;
         pass_cnt    <= '0;
         fail_cnt    <= '0;
         first_fail  <= '0;
         fail_seen   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if ((state == ST_IDLE) && start) begin
            idx         <= '0;
            run_len     <= (num_vec > CW'(DEPTH)) ?
                           CW'(DEPTH) : num_vec;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            first_fail  <= '0;
            fail_seen   <= 1'b0;
            timeout_err <= 1'b0;
         end
         if (hs) tmo <= TW'(TIMEOUT);
         if (state == ST_WAIT) begin
            if (alu.rsp_valid) res <= alu.rsp_result;
            else               tmo <= tmo - TW'(1);
         end
         if (to_ev) timeout_err <= 1'b1;
         if ((state == ST_CHECK) && match)
            pass_cnt <= pass_cnt + CW'(1);
         if (fail_ev) begin
            fail_cnt <= fail_cnt + CW'(1);
            if (!fail_seen) begin
               fail_seen  <= 1'b1;
               first_fail <= idx[AW-1:0];
            end
         end
         if (adv) idx <= idx + CW'(1);
      end
   end
endmodule

// File: tb/tb_fpu_vector_driver.sv
// Directed bench for fpu_vector_driver with a 1-cycle ALU model.
// u0 treats NaNs as equal, u1 compares bit-exactly.
module tb_fpu_vector_driver;
   import fpu_pkg::*;

   localparam int DEPTH = 16;
   localparam int AW = 4;
   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          vec_we;
   logic [AW-1:0] vec_addr;
   logic [1:0]    vec_op;
   logic [31:0]   vec_a, vec_b, vec_exp;
   logic [CW-1:0] num_vec;
   logic          start;
   logic          ready;

   logic          busy0, done0, fs0, to0;
   logic [CW-1:0] pass0, fail0;
   logic [AW-1:0] ff0;
   logic          busy1, done1, fs1, to1;
   logic [CW-1:0] pass1, fail1;
   logic [AW-1:0] ff1;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic [31:0] rsp;
      bit          en;
   } tv_t;

   tv_t tv [DEPTH];
   int  passed = 0;
   int  total  = 0;

   always #5 clk = ~clk;

   fpu_vector_driver_if a0 ();
   fpu_vector_driver_if a1 ();
   assign a0.req_ready = ready;
   assign a1.req_ready = ready;

   fpu_vector_driver #(.DEPTH(DEPTH), .TIMEOUT(4), .NAN_EQ(1)) u0 (
      .clk(clk), .rst(rst), .vec_we(vec_we), .vec_addr(vec_addr),
      .vec_op(vec_op), .vec_a(vec_a), .vec_b(vec_b),
      .vec_exp(vec_exp), .num_vec(num_vec), .start(start),
      .alu(a0), .busy(busy0), .done(done0), .pass_cnt(pass0),
      .fail_cnt(fail0), .first_fail(ff0), .fail_seen(fs0),
      .timeout_err(to0)
   );

   fpu_vector_driver #(.DEPTH(DEPTH), .TIMEOUT(4), .NAN_EQ(0)) u1 (
      .clk(clk), .rst(rst), .vec_we(vec_we), .vec_addr(vec_addr),
      .vec_op(vec_op), .vec_a(vec_a), .vec_b(vec_b),
      .vec_exp(vec_exp), .num_vec(num_vec), .start(start),
      .alu(a1), .busy(busy1), .done(done1), .pass_cnt(pass1),
      .fail_cnt(fail1), .first_fail(ff1), .fail_seen(fs1),
      .timeout_err(to1)
   );

   // ALU models: answer in the cycle after the handshake edge.
   initial begin
      int k;
      bit hs, st;
      k = 0;
      a0.rsp_valid = 1'b0;
      a0.rsp_result = 32'd0;
      forever begin
         @(posedge clk);
         hs = a0.req_valid && a0.req_ready;
         st = start;
         #1;
         a0.rsp_valid = 1'b0;
         if (st) k = 0;
         if (hs && k < DEPTH) begin
            a0.rsp_valid = tv[k].en;
            a0.rsp_result = tv[k].rsp;
            k++;
         end
      end
   end

   initial begin
      int k;
      bit hs, st;
      k = 0;
      a1.rsp_valid = 1'b0;
      a1.rsp_result = 32'd0;
      forever begin
         @(posedge clk);
         hs = a1.req_valid && a1.req_ready;
         st = start;
         #1;
         a1.rsp_valid = 1'b0;
         if (st) k = 0;
         if (hs && k < DEPTH) begin
            a1.rsp_valid = tv[k].en;
            a1.rsp_result = tv[k].rsp;
            k++;
         end
      end
   end

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] want);
      total++;
      if (act === want) passed++;
      else $display("FAIL %s: got %h want %h", name, act, want);
   endtask

   task automatic load(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         vec_we   = 1'b1;
         vec_addr = AW'(i);
         vec_op   = tv[i].op;
         vec_a    = tv[i].a;
         vec_b    = tv[i].b;
         vec_exp  = tv[i].exp;
      end
      @(negedge clk);
      vec_we = 1'b0;
   endtask

   task automatic run(input int nv, input int cyc,
                      output int busy_n, output int done_n,
                      output int req_n);
      busy_n = 0;
      done_n = 0;
      req_n  = 0;
      @(negedge clk);
      num_vec = CW'(nv);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < cyc; c++) begin
         if (busy0) busy_n++;
         if (done0) done_n++;
         if (a0.req_valid && ready) begin
            if (req_n < DEPTH) begin
               chk("req_op", 32'(a0.req_op), 32'(tv[req_n].op));
               chk("req_a", a0.req_a, tv[req_n].a);
               chk("req_b", a0.req_b, tv[req_n].b);
            end
            req_n++;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int bn, dn, rn;
      rst = 1'b1;
      vec_we = 1'b0;
      vec_addr = '0;
      vec_op = 2'd0;
      vec_a = '0;
      vec_b = '0;
      vec_exp = '0;
      num_vec = '0;
      start = 1'b0;
      ready = 1'b1;
      for (int i = 0; i < DEPTH; i++)
         tv[i] = '{2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1};

      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_req_valid", 32'(a0.req_valid), 32'd0);
      chk("rst_req_a", a0.req_a, 32'd0);
      chk("rst_pass", 32'(pass0), 32'd0);
      chk("rst_fail", 32'(fail0), 32'd0);
      chk("rst_timeout", 32'(to0), 32'd0);
      rst = 1'b0;

      // single add vector
      tv[0] = '{2'd0, 32'h3F800000, 32'h40000000,
                32'h40400000, 32'h40400000, 1'b1};
      load(1);
      run(1, 12, bn, dn, rn);
      chk("one_pass", 32'(pass0), 32'd1);
      chk("one_fail", 32'(fail0), 32'd0);
      chk("one_done", 32'(dn), 32'd1);
      chk("one_busy", 32'(bn), 32'd3);
      chk("one_req", 32'(rn), 32'd1);

      // four vectors, wrong product on index 2
      tv[0] = '{2'd0, 32'h3F800000, 32'h3F800000,
                32'h40000000, 32'h40000000, 1'b1};
      tv[1] = '{2'd1, 32'h40400000, 32'h3F800000,
                32'h40000000, 32'h40000000, 1'b1};
      tv[2] = '{2'd2, 32'h40000000, 32'h40400000,
                32'h40C00000, 32'h40A00000, 1'b1};
      tv[3] = '{2'd3, 32'h40C00000, 32'h40000000,
                32'h40400000, 32'h40400000, 1'b1};
      load(4);
      run(4, 30, bn, dn, rn);
      chk("four_pass", 32'(pass0), 32'd3);
      chk("four_fail", 32'(fail0), 32'd1);
      chk("four_first", 32'(ff0), 32'd2);
      chk("four_seen", 32'(fs0), 32'd1);
      chk("four_req", 32'(rn), 32'd4);
      chk("four_done", 32'(dn), 32'd1);

      // ready held low for 5 cycles on vector 0
      ready = 1'b0;
      @(negedge clk);
      num_vec = CW'(1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk("stall_valid", 32'(a0.req_valid), 32'd1);
         chk("stall_a", a0.req_a, tv[0].a);
         chk("stall_b", a0.req_b, tv[0].b);
         chk("stall_op", 32'(a0.req_op), 32'(tv[0].op));
         @(negedge clk);
      end
      ready = 1'b1;
      dn = 0;
      for (int c = 0; c < 10; c++) begin
         if (done0) dn++;
         @(negedge clk);
      end
      chk("stall_done", 32'(dn), 32'd1);
      chk("stall_pass", 32'(pass0), 32'd1);

      // ALU never answers vector 1
      tv[1].en = 1'b0;
      run(2, 20, bn, dn, rn);
      chk("tmo_err", 32'(to0), 32'd1);
      chk("tmo_fail", 32'(fail0), 32'd1);
      chk("tmo_pass", 32'(pass0), 32'd1);
      chk("tmo_first", 32'(ff0), 32'd1);
      chk("tmo_done", 32'(dn), 32'd1);
      tv[1].en = 1'b1;

      // quiet NaN expected, signalling NaN returned
      tv[0] = '{2'd0, 32'h7F800000, 32'hFF800000,
                32'h7FC00000, 32'h7F800001, 1'b1};
      load(1);
      run(1, 10, bn, dn, rn);
      chk("nan_eq1_pass", 32'(pass0), 32'd1);
      chk("nan_eq1_fail", 32'(fail0), 32'd0);
      chk("nan_eq0_pass", 32'(pass1), 32'd0);
      chk("nan_eq0_fail", 32'(fail1), 32'd1);

      // reset while waiting for a response
      tv[0].en = 1'b0;
      @(negedge clk);
      num_vec = CW'(1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("wait_busy", 32'(busy0), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstw_busy", 32'(busy0), 32'd0);
      chk("rstw_done", 32'(done0), 32'd0);
      chk("rstw_valid", 32'(a0.req_valid), 32'd0);
      chk("rstw_pass", 32'(pass0), 32'd0);
      chk("rstw_fail", 32'(fail0), 32'd0);
      dn = 0;
      for (int c = 0; c < 10; c++) begin
         if (done0) dn++;
         @(negedge clk);
      end
      chk("rstw_no_done", 32'(dn), 32'd0);
      tv[0].en = 1'b1;

      // empty run
      run(0, 6, bn, dn, rn);
      chk("empty_done", 32'(dn), 32'd1);
      chk("empty_req", 32'(rn), 32'd0);
      chk("empty_busy", 32'(bn), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
